alu_seq_param: RTL and testbench
================================

ALU_SEQ_PARAM -- requirements
Module: alu_seq_param

Interface
REQ-001 Parameter W, default 4, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 a  input  W  operand A, unsigned.
REQ-005 b  input  W  operand B, unsigned.
REQ-006 mode  input  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 NOT(a).
REQ-007 in_valid  input  1  request present on a/b/mode.
REQ-008 in_ready  output  1  block can accept a request.
REQ-009 y  output  2W  result.
REQ-010 carry  output  1  ADD carry-out / SUB borrow; 0 for other ops.
REQ-011 zero  output  1  y == 0.
REQ-012 div_zero  output  1  DIV with b == 0.
REQ-013 out_valid  output  1  y and flags valid.
REQ-014 out_ready  input  1  consumer accepts result.

Function
REQ-015 FSM states: IDLE, EXEC, ITER, DONE; one request in flight at a time, no overlap.
REQ-016 in_ready SHALL be 1 only in IDLE; acceptance = in_valid && in_ready at a rising edge, capturing a, b, mode into internal registers.
REQ-017 Acceptance of MUL, or of DIV with b != 0: IDLE -> ITER; all other ops: IDLE -> EXEC.
REQ-018 EXEC: compute result from captured operands, go to DONE next edge; out_valid rises 2 cycles after acceptance edge.
REQ-019 ITER: one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle, exactly W steps, then DONE; out_valid rises W+1 cycles after acceptance edge.
REQ-020 DONE: out_valid = 1; y and flags held stable until out_valid && out_ready, then -> IDLE on that edge; in_ready is 1 the following cycle.
REQ-021 ADD: y = zero-extended (W+1)-bit sum; carry = sum bit W.
REQ-022 SUB: y[W-1:0] = (a - b) mod 2^W, y[2W-1:W] = 0; carry = 1 iff a < b.
REQ-023 MUL: y = full 2W-bit unsigned product.
REQ-024 DIV: y[W-1:0] = quotient, y[2W-1:W] = remainder.
REQ-025 DIV with b == 0: no iteration (EXEC path); quotient = all ones, remainder = a, div_zero = 1.
REQ-026 AND/OR/XOR/NOT: W-bit result zero-extended to 2W.
REQ-027 zero computed over all 2W bits of y; div_zero = 0 for all non-DIV ops.
REQ-028 Changes on a/b/mode after acceptance SHALL NOT affect the in-flight result.
REQ-029 in_valid while busy is ignored (not queued); the requester must hold it until in_ready.

Reset
REQ-030 rst asserted at an edge: state -> IDLE, y = 0, carry = zero = div_zero = 0, out_valid = 0, iteration counter = 0; overrides all other activity including mid-ITER and DONE.
REQ-031 in_ready = 0 while rst is high; 1 in the first cycle after rst deasserts.
REQ-032 A request presented in the same cycle as rst is not accepted.

Structure
REQ-033 Shared package alu_pkg holds opcode constants (OP_ADD..OP_NOT) and the FSM state enumeration.
REQ-034 Iterative MUL/DIV datapath SHALL be sub-module alu_iter_unit (parameter W; start, op, a, b in; busy, done, product/quotient/remainder out); top holds FSM, handshake, single-cycle ops and flags.

Verification (W = 4)
REQ-035 ADD a=F b=1, out_ready=1 -> out_valid 2 cycles after acceptance, y=8'h10, carry=1, zero=0.
REQ-036 MUL a=F b=F -> out_valid 5 cycles after acceptance, y=8'hE1; in_ready low throughout.
REQ-037 DIV a=D b=4 -> y=8'h13 (rem 1, quot 3), div_zero=0, 5-cycle latency; DIV a=9 b=0 -> y=8'h9F, div_zero=1, 2-cycle latency.
REQ-038 SUB a=3 b=5 with out_ready low 3 cycles -> y=8'h0E, carry=1 held stable, in_ready=0, until out_ready=1 handshake; in_ready=1 next cycle.
REQ-039 Start DIV a=F b=2, assert rst in 3rd ITER cycle -> next cycle y=0, out_valid=0, flags 0, in_ready=1 after rst release; following AND a=A b=5 -> y=0, zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } alu_state_e;

  // Divide by zero never iterates; it is resolved in a single EXEC cycle.
  function automatic logic is_iter_op(input logic [2:0] op, input logic b_nonzero);
    return (op == OP_MUL) || ((op == OP_DIV) && b_nonzero);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative multiply (shift-add) / divide (restoring) datapath, one step per cycle.
// A single 2W accumulator serves both ops: {upper, lower} = {product hi, lo} for
// MUL and {remainder, quotient} for DIV.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q;
  logic           div_q;
  logic           busy_q;
  logic [CW-1:0]  cnt_q;
  logic [W:0]     sum, diff;

  // One shift-add or shift-subtract step on the accumulator.
  always_comb begin
    acc_d = acc_q;
    sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
    diff  = acc_q[2*W-1:W-1] - {1'b0, opnd_q};
    if (div_q) begin
      if (!diff[W]) acc_d = {diff[W-1:0], acc_q[W-2:0], 1'b1};
      else          acc_d = {acc_q[2*W-2:0], 1'b0};
    end else begin
      if (acc_q[0]) acc_d = {sum, acc_q[W-1:1]};
      else          acc_d = {1'b0, acc_q[2*W-1:1]};
    end
  end

  // Operand load on start, then W steps counted down to terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      div_q  <= (op == OP_DIV);
      acc_q  <= (op == OP_DIV) ? {{W{1'b0}}, a} : {{W{1'b0}}, b};
      opnd_q <= (op == OP_DIV) ? b : a;
      cnt_q  <= CW'(W);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  // done flags the edge that performs the final step.
  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == CW'(1));
  assign product   = acc_q;
  assign quotient  = acc_q[W-1:0];
  assign remainder = acc_q[2*W-1:W];

endmodule

// File: rtl/alu_seq_param.sv
// Sequential ALU: request/response handshake, single-cycle logic/add/sub ops,
// iterative MUL/DIV delegated to alu_iter_unit.
// state | meaning
// IDLE  | ready for a request
// EXEC  | single-cycle op computing from captured operands
// ITER  | alu_iter_unit stepping MUL/DIV
// DONE  | result valid, waiting for out_ready
module alu_seq_param
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2:0]     mode,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*W-1:0] y,
  output logic           carry,
  output logic           zero,
  output logic           div_zero,
  output logic           out_valid,
  input  logic           out_ready
);

  alu_state_e     state_q;
  logic [W-1:0]   a_q, b_q;
  logic [2:0]     mode_q;
  logic [2*W-1:0] y_q;
  logic           carry_q, div_zero_q, out_valid_q, src_iter_q;

  logic           accept, start_iter;
  logic           iter_busy, iter_done;
  logic [2*W-1:0] product;
  logic [W-1:0]   quotient, remainder;
  logic [2*W-1:0] exec_y;
  logic           exec_carry, exec_dz;
  logic [W:0]     sum_w, diff_w;

  assign in_ready   = (state_q == ST_IDLE) && !iter_busy && !rst;
  assign accept     = in_valid && in_ready;
  assign start_iter = accept && is_iter_op(mode, b != '0);

  alu_iter_unit #(.W(W)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (start_iter),
    .op        (mode),
    .a         (a),
    .b         (b),
    .busy      (iter_busy),
    .done      (iter_done),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Single-cycle result from the captured operands.
  always_comb begin
    exec_y     = '0;
    exec_carry = 1'b0;
    exec_dz    = 1'b0;
    sum_w      = {1'b0, a_q} + {1'b0, b_q};
    diff_w     = {1'b0, a_q} - {1'b0, b_q};
    case (mode_q)
      OP_ADD: begin
        exec_y     = {{(W-1){1'b0}}, sum_w};
        exec_carry = sum_w[W];
      end
      OP_SUB: begin
        exec_y     = {{W{1'b0}}, diff_w[W-1:0]};
        exec_carry = diff_w[W];
      end
      OP_DIV: begin
        exec_y  = {a_q, {W{1'b1}}};
        exec_dz = 1'b1;
      end
      OP_AND:  exec_y = {{W{1'b0}}, a_q & b_q};
      OP_OR:   exec_y = {{W{1'b0}}, a_q | b_q};
      OP_XOR:  exec_y = {{W{1'b0}}, a_q ^ b_q};
      OP_NOT:  exec_y = {{W{1'b0}}, ~a_q};
      default: exec_y = '0;
    endcase
  end

  // Control FSM with registered result and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= OP_ADD;
      y_q         <= '0;
      carry_q     <= 1'b0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      src_iter_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q        <= a;
            b_q        <= b;
            mode_q     <= mode;
            src_iter_q <= 1'b0;
            state_q    <= start_iter ? ST_ITER : ST_EXEC;
          end
        end
        ST_EXEC: begin
          y_q         <= exec_y;
          carry_q     <= exec_carry;
          div_zero_q  <= exec_dz;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_ITER: begin
          if (iter_done) begin
            carry_q     <= 1'b0;
            div_zero_q  <= 1'b0;
            src_iter_q  <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Iterative results are read straight from the (then idle) unit accumulator.
  assign y         = src_iter_q ? ((mode_q == OP_MUL) ? product : {remainder, quotient}) : y_q;
  assign carry     = carry_q;
  assign div_zero  = div_zero_q;
  assign zero      = out_valid_q && (y == '0);
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param (W = 4): directed cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_seq_param;

  localparam int W = 4;
  localparam int unsigned MASK = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   a, b;
  logic [2:0]     mode;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] y;
  logic           carry, zero, div_zero, out_valid;
  logic           out_ready;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  alu_seq_param #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .carry     (carry),
    .zero      (zero),
    .div_zero  (div_zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operation's definition.
  function automatic void model(input int unsigned ai, input int unsigned bi, input int unsigned m,
                                output int unsigned ey, output int unsigned ec,
                                output int unsigned ed, output int unsigned el);
    ey = 0; ec = 0; ed = 0; el = 2;
    case (m)
      0: begin ey = ai + bi; ec = (ai + bi) >> W; end
      1: begin ey = (ai - bi) & MASK; ec = (ai < bi) ? 1 : 0; end
      2: begin ey = ai * bi; el = W + 1; end
      3: begin
        if (bi == 0) begin ey = (ai << W) | MASK; ed = 1; end
        else begin ey = ((ai % bi) << W) | (ai / bi); el = W + 1; end
      end
      4: ey = ai & bi;
      5: ey = ai | bi;
      6: ey = ai ^ bi;
      default: ey = (~ai) & MASK;
    endcase
  endfunction

  task automatic run_op(input int unsigned ai, input int unsigned bi, input int unsigned m,
                        input int hold, input string tag);
    int unsigned ey, ec, ed, el;
    int lat;
    bit seen;
    model(ai, bi, m, ey, ec, ed, el);
    @(negedge clk);
    chk({tag, ":in_ready_idle"}, 64'(in_ready), 64'(1));
    a = W'(ai); b = W'(bi); mode = 3'(m);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    // Scramble inputs while busy; in_valid stays high and must be ignored.
    a = W'($urandom()); b = W'($urandom()); mode = 3'($urandom());
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1;
      else chk({tag, ":busy_in_ready"}, 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;
    chk({tag, ":latency"}, 64'(lat), 64'(el));
    chk({tag, ":y"}, 64'(y), 64'(ey));
    chk({tag, ":carry"}, 64'(carry), 64'(ec));
    chk({tag, ":zero"}, 64'(zero), 64'((ey == 0) ? 1 : 0));
    chk({tag, ":div_zero"}, 64'(div_zero), 64'(ed));
    chk({tag, ":done_in_ready"}, 64'(in_ready), 64'(0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ":hold_valid"}, 64'(out_valid), 64'(1));
      chk({tag, ":hold_y"}, 64'(y), 64'(ey));
      chk({tag, ":hold_carry"}, 64'(carry), 64'(ec));
      chk({tag, ":hold_in_ready"}, 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, ":post_valid"}, 64'(out_valid), 64'(0));
    chk({tag, ":post_in_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ra, rb, rm;
    // Reset, with a request presented during reset that must not be taken.
    rst = 1'b1; a = 4'h1; b = 4'h1; mode = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst:in_ready", 64'(in_ready), 64'(0));
    chk("rst:out_valid", 64'(out_valid), 64'(0));
    chk("rst:y", 64'(y), 64'(0));
    chk("rst:flags", 64'({carry, zero, div_zero}), 64'(0));
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst:in_ready_release", 64'(in_ready), 64'(1));
    repeat (3) @(negedge clk);
    chk("rst:no_accept", 64'(out_valid), 64'(0));

    // Directed cases.
    run_op(4'hF, 4'h1, 0, 0, "add_F_1");
    run_op(4'hF, 4'hF, 2, 0, "mul_F_F");
    run_op(4'hD, 4'h4, 3, 0, "div_D_4");
    run_op(4'h9, 4'h0, 3, 0, "div_9_0");
    run_op(4'h3, 4'h5, 1, 3, "sub_3_5");

    // Reset in the third ITER cycle of a divide.
    @(negedge clk);
    a = 4'hF; b = 4'h2; mode = 3'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("midrst:in_ready_in_rst", 64'(in_ready), 64'(0));
    @(negedge clk);
    chk("midrst:y", 64'(y), 64'(0));
    chk("midrst:out_valid", 64'(out_valid), 64'(0));
    chk("midrst:flags", 64'({carry, zero, div_zero}), 64'(0));
    rst = 1'b0;
    #1;
    chk("midrst:in_ready_release", 64'(in_ready), 64'(1));
    run_op(4'hA, 4'h5, 4, 0, "and_A_5");

    // Random operations with random backpressure.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom_range(0, MASK);
      rb = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, MASK);
      rm = $urandom_range(0, 7);
      run_op(ra, rb, rm, int'($urandom_range(0, 2)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
